// File: rtl/bcd_to_seven_segment_display.sv
// bcd_to_seven_segment_display
// Registered BCD to 7-segment decoder for a single digit, with blanking,
// lamp test and an invalid-code flag.
//
// Parameters:
//   ACTIVE_LOW : 0 = lit segment drives 1 (common cathode),
//                1 = all segment outputs inverted (common anode).
// Ports:
//   clk       : system clock, outputs update on rising edge
//   rst_n     : asynchronous active-low reset, forces segments off
//   BCD       : 4-bit digit input, bit 3 MSB
//   lamp_test : light all segments (below blank in priority)
//   blank     : all segments off (highest priority)
//   A..G      : segment drives a (top) through g (middle)
//   invalid   : registered flag, high when the sampled code was 10-15
module bcd_to_seven_segment_display #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] BCD,
  input  logic       lamp_test,
  input  logic       blank,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       F,
  output logic       G,
  output logic       invalid
);

  // Segment vector ordering throughout: [6]=a ... [0]=g
  logic [6:0] decoded;
  logic [6:0] lit;
  logic [6:0] seg_d;
  logic [6:0] seg_q;
  logic       invalid_d;
  logic       invalid_q;

  always_comb begin
    decoded   = '0;
    invalid_d = 1'b0;
    unique case (BCD)
      4'd0:    decoded = 7'b1111110;
      4'd1:    decoded = 7'b0110000;
      4'd2:    decoded = 7'b1101101;
      4'd3:    decoded = 7'b1111001;
      4'd4:    decoded = 7'b0110011;
      4'd5:    decoded = 7'b1011011;
      4'd6:    decoded = 7'b1011111;
      4'd7:    decoded = 7'b1110000;
      4'd8:    decoded = 7'b1111111;
      4'd9:    decoded = 7'b1111011;
      default: begin
        decoded   = '0;
        invalid_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    lit = decoded;
    if (blank)
      lit = '0;
    else if (lamp_test)
      lit = '1;
    // Polarity applied last so blank/lamp/reset all follow the display type
    seg_d = ACTIVE_LOW ? ~lit : lit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q     <= {7{ACTIVE_LOW}};
      invalid_q <= 1'b0;
    end else begin
      seg_q     <= seg_d;
      invalid_q <= invalid_d;
    end
  end

  assign A       = seg_q[6];
  assign B       = seg_q[5];
  assign C       = seg_q[4];
  assign D       = seg_q[3];
  assign E       = seg_q[2];
  assign F       = seg_q[1];
  assign G       = seg_q[0];
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_to_seven_segment_display.sv
// tb_bcd_to_seven_segment_display
// Self-checking bench: a common-cathode and a common-anode instance share
// the same inputs; each is compared against a reference model built from
// the digit table, with directed and random stimulus.
module tb_bcd_to_seven_segment_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] bcd = 4'd0;
  logic       lamp_test = 1'b0;
  logic       blank = 1'b0;
  logic       a0, b0, c0, d0, e0, f0, g0, inv0;
  logic       a1, b1, c1, d1, e1, f1, g1, inv1;

  int n_cmp = 0;
  int n_err = 0;

  // Lit segments ABCDEFG for digits 0-9
  logic [6:0] digit_tab [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  bcd_to_seven_segment_display #(.ACTIVE_LOW(1'b0)) dut_cc (
    .clk(clk), .rst_n(rst_n), .BCD(bcd), .lamp_test(lamp_test), .blank(blank),
    .A(a0), .B(b0), .C(c0), .D(d0), .E(e0), .F(f0), .G(g0), .invalid(inv0)
  );

  bcd_to_seven_segment_display #(.ACTIVE_LOW(1'b1)) dut_ca (
    .clk(clk), .rst_n(rst_n), .BCD(bcd), .lamp_test(lamp_test), .blank(blank),
    .A(a1), .B(b1), .C(c1), .D(d1), .E(e1), .F(f1), .G(g1), .invalid(inv1)
  );

  always #5 clk = ~clk;

  // Expected {ABCDEFG, invalid}
  function automatic logic [7:0] model(input int unsigned code, input bit lt,
                                       input bit bl, input bit al);
    logic [6:0] s;
    if (bl)             s = 7'b0000000;
    else if (lt)        s = 7'b1111111;
    else if (code < 10) s = digit_tab[code];
    else                s = 7'b0000000;
    if (al) s = ~s;
    return {s, (code >= 10)};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got seg=%b inv=%b, expected seg=%b inv=%b",
               tag, obs[7:1], obs[0], exp[7:1], exp[0]);
    end
  endtask

  function automatic logic [7:0] out_cc();
    return {a0, b0, c0, d0, e0, f0, g0, inv0};
  endfunction

  function automatic logic [7:0] out_ca();
    return {a1, b1, c1, d1, e1, f1, g1, inv1};
  endfunction

  // Drive on negedge, check one edge later
  task automatic step(input string tag, input int unsigned code, input bit lt, input bit bl);
    @(negedge clk);
    bcd = code[3:0]; lamp_test = lt; blank = bl;
    @(posedge clk);
    #1;
    check({tag, "_cc"}, out_cc(), model(code, lt, bl, 1'b0));
    check({tag, "_ca"}, out_ca(), model(code, lt, bl, 1'b1));
  endtask

  initial begin
    // Reset held with BCD=8 while clocking
    bcd = 4'd8;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cc", out_cc(), 8'b0000000_0);
    check("reset_ca", out_ca(), 8'b1111111_0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_cc", out_cc(), model(8, 0, 0, 1'b0));
    check("release_ca", out_ca(), model(8, 0, 0, 1'b1));

    for (int unsigned i = 0; i < 10; i++) step("sweep", i, 0, 0);
    for (int unsigned i = 10; i < 16; i++) step("invalid", i, 0, 0);
    step("after_invalid", 2, 0, 0);

    step("lamp5", 5, 1, 0);
    step("blank5", 5, 1, 1);
    step("lamp12", 12, 1, 0);
    step("blank13", 13, 0, 1);

    // Async reset between edges, mid-sweep
    step("pre_async", 6, 0, 0);
    @(negedge clk);
    bcd = 4'd7;
    rst_n = 1'b0;
    #1;
    check("async_cc", out_cc(), 8'b0000000_0);
    check("async_ca", out_ca(), 8'b1111111_0);
    @(posedge clk);
    #1;
    check("async_hold_cc", out_cc(), 8'b0000000_0);
    @(negedge clk);
    rst_n = 1'b1;
    step("resume", 3, 0, 0);
    step("resume2", 9, 0, 0);

    // Active-low specific points
    step("al_zero", 0, 0, 0);
    step("al_one", 1, 0, 0);
    step("al_eleven", 11, 0, 0);

    // Random stimulus
    for (int i = 0; i < 300; i++) begin
      step("rand", $urandom_range(15, 0), ($urandom_range(3, 0) == 0),
           ($urandom_range(5, 0) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
